ifetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the decode stage. It owns the PC and issues requests to the instruction SRAM. It hands the decode stage one word per cycle: an instruction, its PC, and the fetch exception/delay-slot tags. It applies branch/jump redirects from decode after the delay slot, and it applies exception/eret flushes from the CP0 path.

---
 rtl/ifetch.sv | 187 ++++++++++++++++++
 tb/tb_ifetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch: instruction-fetch stage plus the IF/ID pipeline register.
//
// Owns the PC and drives a simple req/ack instruction SRAM port. Each
// consumed word is handed to decode together with its PC and the fetch
// exception / branch-delay-slot tags. Branch and jump redirects from decode
// take effect after the delay slot. CP0 flushes (exception or eret) override
// everything, including stall.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   stall                        hold PC, IF/ID and any buffered fetch
//   cp0_flush, cp0_flush_pc      flush and its redirect target
//   npc_op, br_taken, br_imm,    next-PC selection for the instruction in ID
//   j_index, jr_target
//   inst_req, inst_addr          SRAM request and address (stable until ack)
//   inst_ack, inst_rdata         SRAM acknowledge and returned word
//   id_valid, id_inst, id_pc     IF/ID contents handed to decode
//   if_cp0_ex, if_cp0_excode     fetch address error tag (ADEL = 5'h04)
//   if_cp0_bd                    id_inst sits in a branch delay slot
// ---------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        cp0_flush,
    input  logic [31:0] cp0_flush_pc,
    input  logic [2:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] br_imm,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        if_cp0_ex,
    output logic [4:0]  if_cp0_excode,
    output logic        if_cp0_bd
);

    typedef enum logic [1:0] {S_RST, S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] hold_buf;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic        ds_pend;
    logic        halted;

    logic        aligned;
    logic        word_ready;
    logic        consume;
    logic        misalign_take;
    logic        is_ctl;
    logic        capture;
    logic [31:0] base;
    logic [31:0] word_data;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;

    assign aligned       = (pc[1:0] == 2'b00);
    // DRAIN keeps the abandoned request alive on its original address until
    // the SRAM acknowledges it.
    assign inst_req      = ((state == S_FETCH) && aligned) || (state == S_DRAIN);
    assign inst_addr     = (state == S_DRAIN) ? drain_addr : pc;
    assign if_cp0_excode = if_cp0_ex ? 5'h04 : 5'h00;

    assign word_ready    = ((state == S_FETCH) && aligned && inst_ack) || (state == S_HOLD);
    assign word_data     = (state == S_HOLD) ? hold_buf : inst_rdata;
    assign consume       = word_ready && !stall && !cp0_flush;
    // A misaligned PC is reported to decode once; afterwards the stage idles
    // until CP0 redirects it.
    assign misalign_take = (state == S_FETCH) && !aligned && !halted && !stall && !cp0_flush;

    assign is_ctl  = id_valid && (npc_op != 3'b000);
    assign capture = id_valid && !stall && !cp0_flush &&
                     (((npc_op == 3'b010) && br_taken) || (npc_op == 3'b011) || (npc_op == 3'b100));
    assign base    = id_pc + 32'd4;

    always_comb begin
        redirect_target = base + (br_imm << 2);
        case (npc_op)
            3'b011:  redirect_target = {base[31:28], j_index, 2'b00};
            3'b100:  redirect_target = jr_target;
            default: redirect_target = base + (br_imm << 2);
        endcase
    end

    // When the delay slot is consumed on the same edge that the branch is
    // captured, the new target is used directly instead of going through the
    // pending register.
    assign next_pc = capture ? redirect_target : (pend_valid ? pend_target : pc + 32'd4);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_RST;
            pc          <= RESET_PC;
            drain_addr  <= '0;
            hold_buf    <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            ds_pend     <= 1'b0;
            halted      <= 1'b0;
            id_valid    <= 1'b0;
            id_inst     <= '0;
            id_pc       <= '0;
            if_cp0_ex   <= 1'b0;
            if_cp0_bd   <= 1'b0;
        end else if (cp0_flush) begin
            pc         <= cp0_flush_pc;
            hold_buf   <= '0;
            pend_valid <= 1'b0;
            ds_pend    <= 1'b0;
            halted     <= 1'b0;
            id_valid   <= 1'b0;
            id_inst    <= '0;
            id_pc      <= '0;
            if_cp0_ex  <= 1'b0;
            if_cp0_bd  <= 1'b0;
            if (inst_req && !inst_ack) begin
                state <= S_DRAIN;
                // A flush during DRAIN keeps the original outstanding address.
                if (state != S_DRAIN) begin
                    drain_addr <= pc;
                end
            end else begin
                state <= S_FETCH;
            end
        end else begin
            case (state)
                S_RST:   state <= S_FETCH;
                S_FETCH: begin
                    if (word_ready && stall) begin
                        hold_buf <= inst_rdata;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD:  if (!stall) state <= S_FETCH;
                S_DRAIN: if (inst_ack) state <= S_FETCH;
                default: state <= S_RST;
            endcase

            if (!stall) begin
                if (consume || misalign_take) begin
                    id_valid  <= 1'b1;
                    id_inst   <= consume ? word_data : 32'd0;
                    id_pc     <= pc;
                    if_cp0_ex <= misalign_take;
                    // Delay-slot tag: the branch is leaving ID now, or it
                    // left earlier while the slot was still being fetched.
                    if_cp0_bd <= is_ctl || ds_pend;
                    ds_pend   <= 1'b0;
                end else begin
                    id_valid  <= 1'b0;
                    id_inst   <= '0;
                    id_pc     <= '0;
                    if_cp0_ex <= 1'b0;
                    if_cp0_bd <= 1'b0;
                    if (is_ctl) begin
                        ds_pend <= 1'b1;
                    end
                end

                if (consume) begin
                    pc         <= next_pc;
                    pend_valid <= 1'b0;
                end else if (capture) begin
                    pend_valid  <= 1'b1;
                    pend_target <= redirect_target;
                end

                if (misalign_take) begin
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch: self-checking bench for ifetch.
//
// A directed prologue walks the reset / stall / branch / JR / flush / reset
// scenarios with hand-computed literal expectations, then a long randomized
// phase drives stall, flush, decode redirects, resets and SRAM latency.
// A behavioural model tracks the architectural fetch stream (PC, buffered
// word, dropped request, owed delay slot, redirect queue) and every cycle
// the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        cp0_flush = 1'b0;
    logic [31:0] cp0_flush_pc = '0;
    logic [2:0]  npc_op = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_imm = '0;
    logic [25:0] j_index = '0;
    logic [31:0] jr_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        if_cp0_ex;
    logic [4:0]  if_cp0_excode;
    logic        if_cp0_bd;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn), .stall(stall),
        .cp0_flush(cp0_flush), .cp0_flush_pc(cp0_flush_pc),
        .npc_op(npc_op), .br_taken(br_taken), .br_imm(br_imm),
        .j_index(j_index), .jr_target(jr_target),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .if_cp0_ex(if_cp0_ex), .if_cp0_excode(if_cp0_excode), .if_cp0_bd(if_cp0_bd)
    );

    int checkCount = 0;
    int passCount  = 0;

    // SRAM knobs
    int lat = 0;
    int sramWait = 0;
    bit randomMode = 1'b0;

    // Behavioural model state
    bit          mLive;
    logic [31:0] mPc;
    bit          mHeld;
    logic [31:0] mHeldWord;
    bit          mDrop;
    logic [31:0] mDropAddr;
    bit          mStuck;
    bit          mDsOwed;
    logic [31:0] mRedirectQ[$];
    bit          eValid;
    logic [31:0] eInst;
    logic [31:0] ePc;
    bit          eEx;
    bit          eBd;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h24080001;
        if (a == 32'hBFC00004) return 32'h24090002;
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic bit expReq();
        return mLive && !mHeld && (mDrop || (mPc[1:0] == 2'b00));
    endfunction

    function automatic logic [31:0] expAddr();
        return mDrop ? mDropAddr : mPc;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic modelReset();
        mLive = 0; mPc = RESET_PC; mHeld = 0; mHeldWord = '0;
        mDrop = 0; mDropAddr = '0; mStuck = 0; mDsOwed = 0;
        mRedirectQ.delete();
        eValid = 0; eInst = '0; ePc = '0; eEx = 0; eBd = 0;
    endtask

    task automatic setBubble();
        eValid = 0; eInst = '0; ePc = '0; eEx = 0; eBd = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic modelEdge();
        bit          req;
        bit          gotWord;
        logic [31:0] word;
        bit          ctl;
        bit          taken;
        logic [31:0] seqPc;
        logic [31:0] tgt;
        bit          canTakeMisaligned;
        if (!resetn) return;
        req     = expReq();
        gotWord = (req && !mDrop && inst_ack) || mHeld;
        word    = mHeld ? mHeldWord : inst_rdata;
        ctl     = eValid && (npc_op != 3'b000);
        taken   = eValid && (((npc_op == 3'b010) && br_taken) || npc_op == 3'b011 || npc_op == 3'b100);
        seqPc   = ePc + 32'd4;
        if (npc_op == 3'b011) tgt = {seqPc[31:28], j_index, 2'b00};
        else if (npc_op == 3'b100) tgt = jr_target;
        else tgt = seqPc + br_imm * 4;
        canTakeMisaligned = mLive && !mDrop && !mHeld && (mPc[1:0] != 2'b00) && !mStuck;

        if (cp0_flush) begin
            if (req && !inst_ack) begin
                if (!mDrop) mDropAddr = mPc;
                mDrop = 1;
            end else begin
                mDrop = 0;
            end
            mPc = cp0_flush_pc;
            mHeld = 0; mStuck = 0; mDsOwed = 0;
            mRedirectQ.delete();
            setBubble();
        end else begin
            if (mDrop && inst_ack) mDrop = 0;
            if (stall) begin
                if (gotWord && !mHeld) begin
                    mHeld = 1;
                    mHeldWord = inst_rdata;
                end
            end else if (gotWord) begin
                eValid = 1; eInst = word; ePc = mPc; eEx = 0; eBd = ctl || mDsOwed;
                mHeld = 0; mDsOwed = 0;
                if (taken) mPc = tgt;
                else if (mRedirectQ.size() > 0) mPc = mRedirectQ[0];
                else mPc = mPc + 32'd4;
                mRedirectQ.delete();
            end else if (canTakeMisaligned) begin
                eValid = 1; eInst = '0; ePc = mPc; eEx = 1; eBd = ctl || mDsOwed;
                mStuck = 1; mDsOwed = 0;
                if (taken) begin mRedirectQ.delete(); mRedirectQ.push_back(tgt); end
            end else begin
                setBubble();
                if (ctl) mDsOwed = 1;
                if (taken) begin mRedirectQ.delete(); mRedirectQ.push_back(tgt); end
            end
        end
        mLive = 1;
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        checkVal("inst_req", inst_req, expReq());
        checkVal("inst_addr", inst_addr, expAddr());
        checkVal("id_valid", id_valid, eValid);
        checkVal("id_inst", id_inst, eInst);
        checkVal("id_pc", id_pc, ePc);
        checkVal("if_cp0_ex", if_cp0_ex, eEx);
        checkVal("if_cp0_excode", if_cp0_excode, eEx ? 32'h4 : 32'h0);
        checkVal("if_cp0_bd", if_cp0_bd, eBd);
    endtask

    // Drive inputs for the coming edge: random knobs when enabled, then the
    // SRAM response to whatever the DUT is requesting.
    task automatic applyStimulus();
        logic [7:0]  imm8;
        logic [31:0] r;
        if (randomMode) begin
            stall        = ($urandom_range(0, 3) == 0);
            cp0_flush    = ($urandom_range(0, 39) == 0);
            cp0_flush_pc = RESET_PC + ($urandom_range(0, 1023) << 2) +
                           (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            case ($urandom_range(0, 6))
                3: npc_op = 3'b010;
                4: npc_op = 3'b011;
                5: npc_op = 3'b100;
                6: npc_op = 3'b001;
                default: npc_op = 3'b000;
            endcase
            br_taken  = 1'($urandom_range(0, 1));
            imm8      = 8'($urandom);
            br_imm    = {{24{imm8[7]}}, imm8};
            j_index   = 26'($urandom);
            r         = $urandom;
            jr_target = ($urandom_range(0, 15) == 0) ? {r[31:2], 2'b10} : {r[31:2], 2'b00};
            resetn    = ($urandom_range(0, 699) != 0);
        end
        if (inst_req) begin
            inst_ack   = (sramWait >= lat);
            sramWait   = inst_ack ? 0 : sramWait + 1;
            inst_rdata = memWord(inst_addr);
        end else begin
            inst_ack   = 1'b0;
            sramWait   = 0;
            inst_rdata = $urandom;
        end
    endtask

    task automatic tick();
        applyStimulus();
        if (!resetn) modelReset();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        modelReset();
        // Reset state
        tick();
        tick();
        checkVal("rst inst_req", inst_req, 0);
        checkVal("rst id_valid", id_valid, 0);
        checkVal("rst id_inst", id_inst, 0);
        checkVal("rst id_pc", id_pc, 0);

        // Reset release, zero-wait SRAM
        resetn = 1'b1;
        tick();
        checkVal("first req", inst_req, 1);
        checkVal("first addr", inst_addr, 32'hBFC00000);
        checkVal("pre-ack id_valid", id_valid, 0);
        tick();
        checkVal("word0 inst", id_inst, 32'h24080001);
        checkVal("word0 pc", id_pc, 32'hBFC00000);
        checkVal("addr1", inst_addr, 32'hBFC00004);
        tick();
        checkVal("word1 inst", id_inst, 32'h24090002);
        checkVal("word1 pc", id_pc, 32'hBFC00004);

        // Three-cycle stall across an ack
        stall = 1'b1;
        tick();
        checkVal("hold req low", inst_req, 0);
        checkVal("hold id_pc", id_pc, 32'hBFC00004);
        tick();
        tick();
        checkVal("hold id_pc late", id_pc, 32'hBFC00004);
        stall = 1'b0;
        tick();
        checkVal("buffered pc", id_pc, 32'hBFC00008);
        checkVal("buffered inst", id_inst, memWord(32'hBFC00008));
        tick();
        checkVal("post-hold pc", id_pc, 32'hBFC0000C);
        tick();
        checkVal("beq in id", id_pc, 32'hBFC00010);

        // Taken BEQ at 0xBFC00010, offset 3
        npc_op = 3'b010; br_taken = 1'b1; br_imm = 32'd3;
        tick();
        checkVal("beq slot pc", id_pc, 32'hBFC00014);
        checkVal("beq slot bd", if_cp0_bd, 1);
        checkVal("beq target", inst_addr, 32'hBFC00020);
        npc_op = 3'b000; br_taken = 1'b0;
        tick();
        checkVal("beq target pc", id_pc, 32'hBFC00020);
        checkVal("beq target bd", if_cp0_bd, 0);

        // JR to a misaligned target
        npc_op = 3'b100; jr_target = 32'hBFC00102;
        tick();
        checkVal("jr slot pc", id_pc, 32'hBFC00024);
        checkVal("jr slot bd", if_cp0_bd, 1);
        checkVal("jr addr", inst_addr, 32'hBFC00102);
        checkVal("jr no req", inst_req, 0);
        npc_op = 3'b000;
        tick();
        checkVal("adel pc", id_pc, 32'hBFC00102);
        checkVal("adel ex", if_cp0_ex, 1);
        checkVal("adel code", if_cp0_excode, 32'h04);
        checkVal("adel inst", id_inst, 0);

        // Flush with a slow SRAM request outstanding
        lat = 2; cp0_flush = 1'b1; cp0_flush_pc = 32'hBFC00200;
        tick();
        cp0_flush = 1'b0;
        checkVal("flush1 addr", inst_addr, 32'hBFC00200);
        tick();
        cp0_flush = 1'b1; cp0_flush_pc = 32'hBFC00380;
        tick();
        cp0_flush = 1'b0;
        checkVal("drain req", inst_req, 1);
        checkVal("drain addr", inst_addr, 32'hBFC00200);
        tick();
        checkVal("drained bubble", id_valid, 0);
        checkVal("drained inst", id_inst, 0);
        checkVal("vector addr", inst_addr, 32'hBFC00380);
        lat = 0;
        tick();
        checkVal("vector pc", id_pc, 32'hBFC00380);

        // Reset asserted while in HOLD
        stall = 1'b1;
        tick();
        checkVal("hold2 req", inst_req, 0);
        resetn = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkVal("async rst valid", id_valid, 0);
        checkVal("async rst pc", id_pc, 0);
        checkVal("async rst addr", inst_addr, RESET_PC);
        stall = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        checkVal("restart addr", inst_addr, RESET_PC);
        checkVal("restart req", inst_req, 1);
        tick();
        checkVal("restart inst", id_inst, 32'h24080001);

        // Randomized phase
        randomMode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(0, 3);
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
